// File: rtl/divider_32_bit_if.sv
// -----------------------------------------------------------------------------
// divider_32_bit_if
//
// Request/response bundle between the ALU control sequencer and the
// sequential 32-bit unsigned divider.
//
// Signals:
//   start        sequencer -> divider  request pulse, sampled only when idle
//   dividend     sequencer -> divider  unsigned dividend, sampled with start
//   divisor      sequencer -> divider  unsigned divisor, sampled with start
//   busy         divider -> sequencer  high while a request is in flight
//   done         divider -> sequencer  one-cycle pulse, results valid
//   quotient     divider -> sequencer  unsigned quotient
//   remainder    divider -> sequencer  unsigned remainder
//   div_by_zero  divider -> sequencer  last accepted request had divisor 0
//
// Modports:
//   master  the sequencer side (drives the request)
//   slave   the divider side (drives the results)
// -----------------------------------------------------------------------------
interface divider_32_bit_if;

    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    modport master (
        output start,
        output dividend,
        output divisor,
        input  busy,
        input  done,
        input  quotient,
        input  remainder,
        input  div_by_zero
    );

    modport slave (
        input  start,
        input  dividend,
        input  divisor,
        output busy,
        output done,
        output quotient,
        output remainder,
        output div_by_zero
    );

endinterface : divider_32_bit_if

// File: rtl/divider_32_bit.sv
// -----------------------------------------------------------------------------
// divider_32_bit
//
// Sequential unsigned 32-bit restoring divider. A request is accepted on
// start while idle; one quotient bit is produced per clock using a 33-bit
// trial subtraction, so a non-zero divisor takes 32 iterations. A zero
// divisor skips the iterations and reports quotient = all ones,
// remainder = dividend and div_by_zero = 1.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    divider_32_bit_if.slave
//            start/dividend/divisor in, busy/done/quotient/remainder/
//            div_by_zero out (all outputs registered)
//
// Timing (non-zero divisor): start sampled at edge E0, busy from E0,
// done high during the cycle after E32, busy falls at E33.
// Zero divisor: done high during the cycle after E0, busy falls at E1.
// -----------------------------------------------------------------------------
module divider_32_bit (
    input  logic                  clk,
    input  logic                  rst_n,
    divider_32_bit_if.slave       bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Partial remainder and shifted quotient produced by one iteration.
    typedef struct packed {
        logic [31:0] r;
        logic [31:0] q;
    } step_t;

    // One restoring iteration. The partial remainder is always below the
    // divisor, so S < 2*D and the 33-bit difference is either a value that
    // fits in 32 bits (bit 32 clear) or a wrapped negative (bit 32 set);
    // bit 32 therefore acts as the borrow flag.
    function automatic step_t restoring_step(
        input logic [31:0] r_in,
        input logic [31:0] q_in,
        input logic [31:0] d_in
    );
        step_t       res;
        logic [32:0] s;
        logic [32:0] t;
        s = {r_in, q_in[31]};
        t = s - {1'b0, d_in};
        if (t[32] == 1'b0) begin
            res.r = t[31:0];
            res.q = {q_in[30:0], 1'b1};
        end else begin
            res.r = s[31:0];
            res.q = {q_in[30:0], 1'b0};
        end
        return res;
    endfunction

    state_t      state_r;
    logic [31:0] d_r;
    logic [31:0] q_r;
    logic [31:0] r_r;
    logic [4:0]  count_r;
    logic        busy_r;
    logic        done_r;
    logic [31:0] quotient_r;
    logic [31:0] remainder_r;
    logic        div_by_zero_r;
    step_t       step_s;

    // Next partial remainder/quotient from the current working registers.
    always_comb begin
        step_s = '0;
        step_s = restoring_step(r_r, q_r, d_r);
    end

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            d_r           <= 32'd0;
            q_r           <= 32'd0;
            r_r           <= 32'd0;
            count_r       <= 5'd0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            quotient_r    <= 32'd0;
            remainder_r   <= 32'd0;
            div_by_zero_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start == 1'b1) begin
                        busy_r <= 1'b1;
                        if (bus.divisor != 32'd0) begin
                            d_r           <= bus.divisor;
                            q_r           <= bus.dividend;
                            r_r           <= 32'd0;
                            count_r       <= 5'd0;
                            div_by_zero_r <= 1'b0;
                            state_r       <= RUN;
                        end else begin
                            // Zero divisor: publish the fixed result now and
                            // go straight to the single DONE cycle.
                            quotient_r    <= 32'hFFFF_FFFF;
                            remainder_r   <= bus.dividend;
                            div_by_zero_r <= 1'b1;
                            done_r        <= 1'b1;
                            state_r       <= DONE;
                        end
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                end

                RUN: begin
                    q_r     <= step_s.q;
                    r_r     <= step_s.r;
                    count_r <= count_r + 5'd1;
                    if (count_r == 5'd31) begin
                        // Last of 32 iterations: results go straight to the
                        // outputs so they are valid with the done pulse.
                        quotient_r  <= step_s.q;
                        remainder_r <= step_s.r;
                        done_r      <= 1'b1;
                        state_r     <= DONE;
                    end else begin
                        state_r <= RUN;
                    end
                end

                DONE: begin
                    // start is deliberately not looked at here; the earliest
                    // follow-on request is taken in the next IDLE cycle.
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end

                default: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.quotient    = quotient_r;
    assign bus.remainder   = remainder_r;
    assign bus.div_by_zero = div_by_zero_r;

endmodule : divider_32_bit

// File: tb/tb_divider_32_bit.sv
// -----------------------------------------------------------------------------
// tb_divider_32_bit
//
// Self-checking bench for divider_32_bit: directed vector table, hand-written
// sequences for start-while-busy and reset mid-operation, and a batch of
// random pairs against the language's own / and % operators.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_divider_32_bit;

    logic clk;
    logic rst_n;

    divider_32_bit_if dif ();

    divider_32_bit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (dif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        z;
        int          lat;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Count falling edges until done is seen (bounded); start drops after the
    // first edge so a request is presented for exactly one rising edge.
    task automatic wait_done(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            dif.start = 1'b0;
            lat++;
        end while (dif.done !== 1'b1 && lat < 100);
        if (dif.done !== 1'b1) check("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] q, output logic [31:0] r,
                           output logic z, output int lat);
        @(negedge clk);
        dif.start    = 1'b1;
        dif.dividend = a;
        dif.divisor  = b;
        wait_done(lat);
        q = dif.quotient;
        r = dif.remainder;
        z = dif.div_by_zero;
    endtask

    // Global time limit so the run always ends.
    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] q, r, a, b;
        logic [31:0] eq, er;
        logic        z, ez, saw_done;
        int          lat;

        vecs[0] = '{32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 33};
        vecs[1] = '{32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0, 33};
        vecs[2] = '{32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  1'b0, 33};
        vecs[3] = '{32'hFFFF_FFFF,  32'h8000_0001,  32'd1,          32'h7FFF_FFFE,  1'b0, 33};
        vecs[4] = '{32'h1234,       32'd0,          32'hFFFF_FFFF,  32'h1234,       1'b1, 1};
        vecs[5] = '{32'd1000,       32'd3,          32'd333,        32'd1,          1'b0, 33};
        vecs[6] = '{32'd0,          32'd5,          32'd0,          32'd0,          1'b0, 33};
        vecs[7] = '{32'd7,          32'd7,          32'd1,          32'd0,          1'b0, 33};
        vecs[8] = '{32'd6,          32'd7,          32'd0,          32'd6,          1'b0, 33};

        rst_n        = 1'b0;
        dif.start    = 1'b0;
        dif.dividend = 32'd0;
        dif.divisor  = 32'd0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy", {63'd0, dif.busy}, 64'd0);
        check("rst_done", {63'd0, dif.done}, 64'd0);
        check("rst_quotient", {32'd0, dif.quotient}, 64'd0);
        check("rst_remainder", {32'd0, dif.remainder}, 64'd0);
        check("rst_dbz", {63'd0, dif.div_by_zero}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy", {63'd0, dif.busy}, 64'd0);

        // Directed vector table
        foreach (vecs[i]) begin
            run_div(vecs[i].a, vecs[i].b, q, r, z, lat);
            check($sformatf("vec%0d_quotient", i), {32'd0, q}, {32'd0, vecs[i].q});
            check($sformatf("vec%0d_remainder", i), {32'd0, r}, {32'd0, vecs[i].r});
            check($sformatf("vec%0d_dbz", i), {63'd0, z}, {63'd0, vecs[i].z});
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
            @(negedge clk);
            check($sformatf("vec%0d_done_pulse", i), {63'd0, dif.done}, 64'd0);
            check($sformatf("vec%0d_busy_fall", i), {63'd0, dif.busy}, 64'd0);
            check($sformatf("vec%0d_hold_q", i), {32'd0, dif.quotient}, {32'd0, vecs[i].q});
        end

        // Start while busy: pulses at cycle 10 and in the DONE cycle are ignored
        @(negedge clk);
        dif.start    = 1'b1;
        dif.dividend = 32'd100;
        dif.divisor  = 32'd7;
        lat = 0;
        do begin
            @(negedge clk);
            dif.start = 1'b0;
            lat++;
            if (lat == 10) begin
                dif.start    = 1'b1;
                dif.dividend = 32'd50;
                dif.divisor  = 32'd5;
            end
        end while (dif.done !== 1'b1 && lat < 100);
        check("busy_latency", 64'(lat), 64'd33);
        check("busy_quotient", {32'd0, dif.quotient}, 64'd14);
        check("busy_remainder", {32'd0, dif.remainder}, 64'd2);
        dif.start    = 1'b1;
        dif.dividend = 32'd50;
        dif.divisor  = 32'd5;
        @(negedge clk);
        check("done_start_ignored", {63'd0, dif.busy}, 64'd0);
        check("hold_quotient", {32'd0, dif.quotient}, 64'd14);
        check("hold_remainder", {32'd0, dif.remainder}, 64'd2);
        // start is still high here, so it is taken in this IDLE cycle
        wait_done(lat);
        check("b2b_latency", 64'(lat), 64'd33);
        check("b2b_quotient", {32'd0, dif.quotient}, 64'd10);
        check("b2b_remainder", {32'd0, dif.remainder}, 64'd0);
        @(negedge clk);

        // Reset mid-operation
        @(negedge clk);
        dif.start    = 1'b1;
        dif.dividend = 32'd1000;
        dif.divisor  = 32'd3;
        repeat (14) begin
            @(negedge clk);
            dif.start = 1'b0;
        end
        check("mid_busy_before_rst", {63'd0, dif.busy}, 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", {63'd0, dif.busy}, 64'd0);
        check("mid_rst_done", {63'd0, dif.done}, 64'd0);
        check("mid_rst_quotient", {32'd0, dif.quotient}, 64'd0);
        check("mid_rst_remainder", {32'd0, dif.remainder}, 64'd0);
        check("mid_rst_dbz", {63'd0, dif.div_by_zero}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (dif.done === 1'b1) saw_done = 1'b1;
        end
        check("no_done_after_rst", {63'd0, saw_done}, 64'd0);
        run_div(32'd1000, 32'd3, q, r, z, lat);
        check("post_rst_quotient", {32'd0, q}, 64'd333);
        check("post_rst_remainder", {32'd0, r}, 64'd1);

        // Random pairs against a reference model
        for (int i = 0; i < 200; i++) begin
            a = $urandom;
            b = $urandom;
            if (i % 3 == 0) b = $urandom_range(1, 255);
            if (i % 7 == 0) b = b >> $urandom_range(0, 31);
            if (i % 50 == 0) b = 32'd0;
            if (b == 32'd0) begin
                eq = 32'hFFFF_FFFF;
                er = a;
                ez = 1'b1;
            end else begin
                eq = a / b;
                er = a % b;
                ez = 1'b0;
            end
            run_div(a, b, q, r, z, lat);
            check($sformatf("rnd%0d_quotient", i), {32'd0, q}, {32'd0, eq});
            check($sformatf("rnd%0d_remainder", i), {32'd0, r}, {32'd0, er});
            check($sformatf("rnd%0d_dbz", i), {63'd0, z}, {63'd0, ez});
            if (b != 32'd0) begin
                check($sformatf("rnd%0d_identity", i),
                      64'(q) * 64'(b) + 64'(r), 64'(a));
                check($sformatf("rnd%0d_rem_lt_div", i), {63'd0, (r < b)}, 64'd1);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_divider_32_bit
